// File: rtl/rs_ordered_multi_cdb.sv
// Reservation station for one functional unit: multi-port CDB wakeup with insert bypass,
// oldest-ready issue tracked by an age matrix so ordering is independent of slot position.
module rs_ordered_multi_cdb #(
    parameter int RS_SIZE      = 8,
    parameter int RS_IDX_SIZE  = 3,
    parameter int NUM_SRC      = 2,
    parameter int NUM_CDB      = 2,
    parameter int GPR_SIZE     = 64,
    parameter int ROB_IDX_SIZE = 4,
    parameter int OP_SIZE      = 6
) (
    input  logic                             in_clk,
    input  logic                             in_rst,
    input  logic                             in_flush,
    input  logic                             in_disp_valid,
    output logic                             out_disp_ready,
    input  logic [OP_SIZE-1:0]               in_disp_op,
    input  logic [ROB_IDX_SIZE-1:0]          in_disp_dst,
    input  logic [NUM_SRC-1:0]               in_disp_src_valid,
    input  logic [NUM_SRC*GPR_SIZE-1:0]      in_disp_src_value,
    input  logic [NUM_SRC*ROB_IDX_SIZE-1:0]  in_disp_src_tag,
    input  logic                             in_disp_uses_nzcv,
    input  logic                             in_disp_nzcv_valid,
    input  logic [3:0]                       in_disp_nzcv,
    input  logic [ROB_IDX_SIZE-1:0]          in_disp_nzcv_tag,
    input  logic [NUM_CDB-1:0]               in_cdb_valid,
    input  logic [NUM_CDB*ROB_IDX_SIZE-1:0]  in_cdb_tag,
    input  logic [NUM_CDB*GPR_SIZE-1:0]      in_cdb_value,
    input  logic [NUM_CDB-1:0]               in_cdb_set_nzcv,
    input  logic [NUM_CDB*4-1:0]             in_cdb_nzcv,
    output logic                             out_issue_valid,
    input  logic                             in_issue_ready,
    output logic [OP_SIZE-1:0]               out_issue_op,
    output logic [ROB_IDX_SIZE-1:0]          out_issue_dst,
    output logic [NUM_SRC*GPR_SIZE-1:0]      out_issue_src,
    output logic [3:0]                       out_issue_nzcv,
    output logic [RS_IDX_SIZE:0]             out_count
);

    logic [RS_SIZE-1:0]      valid_q;
    logic [OP_SIZE-1:0]      op_q        [RS_SIZE];
    logic [ROB_IDX_SIZE-1:0] dst_q       [RS_SIZE];
    logic [NUM_SRC-1:0]      src_valid_q [RS_SIZE];
    logic [GPR_SIZE-1:0]     src_value_q [RS_SIZE][NUM_SRC];
    logic [ROB_IDX_SIZE-1:0] src_tag_q   [RS_SIZE][NUM_SRC];
    logic [RS_SIZE-1:0]      uses_nzcv_q;
    logic [RS_SIZE-1:0]      nzcv_valid_q;
    logic [3:0]              nzcv_q      [RS_SIZE];
    logic [ROB_IDX_SIZE-1:0] nzcv_tag_q  [RS_SIZE];
    // older_q[j][i] set means entry j was inserted before entry i
    logic [RS_SIZE-1:0]      older_q     [RS_SIZE];

    logic [RS_SIZE-1:0]      ready;
    logic [RS_SIZE-1:0]      sel;
    logic                    full;
    logic                    fire;
    logic                    insert;
    logic [RS_IDX_SIZE-1:0]  ins_idx;

    logic [GPR_SIZE:0]       src_wake      [RS_SIZE][NUM_SRC];
    logic [4:0]              nzcv_wake     [RS_SIZE];
    logic [GPR_SIZE:0]       disp_src_wake [NUM_SRC];
    logic [4:0]              disp_nzcv_wake;

    // Lowest-numbered matching port wins because it is assigned last.
    function automatic logic [GPR_SIZE:0] value_lookup(
        input logic [ROB_IDX_SIZE-1:0]         tag,
        input logic [NUM_CDB-1:0]              cdb_valid,
        input logic [NUM_CDB*ROB_IDX_SIZE-1:0] cdb_tag,
        input logic [NUM_CDB*GPR_SIZE-1:0]     cdb_value
    );
        logic [GPR_SIZE:0] hit;
        hit = '0;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (cdb_valid[p] && cdb_tag[p*ROB_IDX_SIZE +: ROB_IDX_SIZE] == tag)
                hit = {1'b1, cdb_value[p*GPR_SIZE +: GPR_SIZE]};
        end
        return hit;
    endfunction

    function automatic logic [4:0] nzcv_lookup(
        input logic [ROB_IDX_SIZE-1:0]         tag,
        input logic [NUM_CDB-1:0]              cdb_valid,
        input logic [NUM_CDB-1:0]              cdb_set_nzcv,
        input logic [NUM_CDB*ROB_IDX_SIZE-1:0] cdb_tag,
        input logic [NUM_CDB*4-1:0]            cdb_nzcv
    );
        logic [4:0] hit;
        hit = '0;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (cdb_valid[p] && cdb_set_nzcv[p] && cdb_tag[p*ROB_IDX_SIZE +: ROB_IDX_SIZE] == tag)
                hit = {1'b1, cdb_nzcv[p*4 +: 4]};
        end
        return hit;
    endfunction

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            for (int s = 0; s < NUM_SRC; s++)
                src_wake[i][s] = value_lookup(src_tag_q[i][s], in_cdb_valid, in_cdb_tag, in_cdb_value);
            nzcv_wake[i] = nzcv_lookup(nzcv_tag_q[i], in_cdb_valid, in_cdb_set_nzcv, in_cdb_tag, in_cdb_nzcv);
        end
        for (int s = 0; s < NUM_SRC; s++)
            disp_src_wake[s] = value_lookup(in_disp_src_tag[s*ROB_IDX_SIZE +: ROB_IDX_SIZE],
                                            in_cdb_valid, in_cdb_tag, in_cdb_value);
        disp_nzcv_wake = nzcv_lookup(in_disp_nzcv_tag, in_cdb_valid, in_cdb_set_nzcv, in_cdb_tag, in_cdb_nzcv);
    end

    always_comb begin
        out_count = '0;
        ins_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++)
            out_count = out_count + {{RS_IDX_SIZE{1'b0}}, valid_q[i]};
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (!valid_q[i]) ins_idx = RS_IDX_SIZE'(i);
    end

    assign full           = &valid_q;
    assign out_disp_ready = !full && !in_flush;
    assign insert         = in_disp_valid && out_disp_ready;
    assign fire           = out_issue_valid && in_issue_ready;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++)
            ready[i] = valid_q[i] && (&src_valid_q[i]) && (!uses_nzcv_q[i] || nzcv_valid_q[i]);
    end

    // An entry is selected when no other ready entry is older than it; the age order is total.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            sel[i] = ready[i];
            for (int j = 0; j < RS_SIZE; j++)
                if (ready[j] && older_q[j][i]) sel[i] = 1'b0;
        end
    end

    always_comb begin
        out_issue_valid = |ready;
        out_issue_op    = '0;
        out_issue_dst   = '0;
        out_issue_src   = '0;
        out_issue_nzcv  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (sel[i]) begin
                out_issue_op   = out_issue_op   | op_q[i];
                out_issue_dst  = out_issue_dst  | dst_q[i];
                out_issue_nzcv = out_issue_nzcv | nzcv_q[i];
                for (int s = 0; s < NUM_SRC; s++)
                    out_issue_src[s*GPR_SIZE +: GPR_SIZE] = out_issue_src[s*GPR_SIZE +: GPR_SIZE] | src_value_q[i][s];
            end
        end
    end

    // Insert writes come last so they override any wakeup computed for the free slot.
    always_ff @(posedge in_clk) begin
        if (in_rst || in_flush) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (fire && sel[i])
                    valid_q[i] <= 1'b0;
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (!src_valid_q[i][s] && src_wake[i][s][GPR_SIZE]) begin
                        src_valid_q[i][s] <= 1'b1;
                        src_value_q[i][s] <= src_wake[i][s][GPR_SIZE-1:0];
                    end
                end
                if (uses_nzcv_q[i] && !nzcv_valid_q[i] && nzcv_wake[i][4]) begin
                    nzcv_valid_q[i] <= 1'b1;
                    nzcv_q[i]       <= nzcv_wake[i][3:0];
                end
            end
            if (insert) begin
                valid_q[ins_idx]     <= 1'b1;
                op_q[ins_idx]        <= in_disp_op;
                dst_q[ins_idx]       <= in_disp_dst;
                uses_nzcv_q[ins_idx] <= in_disp_uses_nzcv;
                nzcv_tag_q[ins_idx]  <= in_disp_nzcv_tag;
                for (int s = 0; s < NUM_SRC; s++) begin
                    src_tag_q[ins_idx][s]   <= in_disp_src_tag[s*ROB_IDX_SIZE +: ROB_IDX_SIZE];
                    src_valid_q[ins_idx][s] <= in_disp_src_valid[s] | disp_src_wake[s][GPR_SIZE];
                    src_value_q[ins_idx][s] <= in_disp_src_valid[s] ? in_disp_src_value[s*GPR_SIZE +: GPR_SIZE]
                                                                    : disp_src_wake[s][GPR_SIZE-1:0];
                end
                if (!in_disp_nzcv_valid && in_disp_uses_nzcv && disp_nzcv_wake[4]) begin
                    nzcv_valid_q[ins_idx] <= 1'b1;
                    nzcv_q[ins_idx]       <= disp_nzcv_wake[3:0];
                end else begin
                    nzcv_valid_q[ins_idx] <= in_disp_nzcv_valid;
                    nzcv_q[ins_idx]       <= in_disp_nzcv;
                end
                for (int j = 0; j < RS_SIZE; j++)
                    older_q[j][ins_idx] <= 1'b1;
                older_q[ins_idx] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rs_ordered_multi_cdb.sv
// Self-checking bench: directed scenarios plus random traffic against an insertion-ordered queue model.
module tb_rs_ordered_multi_cdb;

    logic         clk = 1'b0;
    logic         rst, flush, disp_valid, disp_ready;
    logic [5:0]   disp_op;
    logic [3:0]   disp_dst;
    logic [1:0]   src_valid;
    logic [127:0] src_value;
    logic [7:0]   src_tag;
    logic         uses_nzcv, nzcv_valid;
    logic [3:0]   disp_nzcv, nzcv_tag;
    logic [1:0]   cdb_valid, cdb_set_nzcv;
    logic [7:0]   cdb_tag, cdb_nzcv;
    logic [127:0] cdb_value;
    logic         issue_valid, issue_ready;
    logic [5:0]   issue_op;
    logic [3:0]   issue_dst, issue_nzcv;
    logic [127:0] issue_src;
    logic [3:0]   count;

    int pass_count  = 0;
    int check_count = 0;

    typedef struct {
        logic [5:0]       op;
        logic [3:0]       dst;
        logic [1:0]       sv;
        logic [1:0][63:0] val;
        logic [1:0][3:0]  tag;
        logic             un;
        logic             nv;
        logic [3:0]       nz;
        logic [3:0]       ntag;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    rs_ordered_multi_cdb dut (
        .in_clk(clk), .in_rst(rst), .in_flush(flush),
        .in_disp_valid(disp_valid), .out_disp_ready(disp_ready),
        .in_disp_op(disp_op), .in_disp_dst(disp_dst),
        .in_disp_src_valid(src_valid), .in_disp_src_value(src_value), .in_disp_src_tag(src_tag),
        .in_disp_uses_nzcv(uses_nzcv), .in_disp_nzcv_valid(nzcv_valid),
        .in_disp_nzcv(disp_nzcv), .in_disp_nzcv_tag(nzcv_tag),
        .in_cdb_valid(cdb_valid), .in_cdb_tag(cdb_tag), .in_cdb_value(cdb_value),
        .in_cdb_set_nzcv(cdb_set_nzcv), .in_cdb_nzcv(cdb_nzcv),
        .out_issue_valid(issue_valid), .in_issue_ready(issue_ready),
        .out_issue_op(issue_op), .out_issue_dst(issue_dst),
        .out_issue_src(issue_src), .out_issue_nzcv(issue_nzcv),
        .out_count(count)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    function automatic int firstReady();
        for (int i = 0; i < q.size(); i++)
            if (q[i].sv == 2'b11 && (!q[i].un || q[i].nv)) return i;
        return -1;
    endfunction

    // First port carrying the tag supplies the value; flags need the port's set_nzcv.
    function automatic logic [64:0] cdbValue(input logic [3:0] tag);
        for (int p = 0; p < 2; p++)
            if (cdb_valid[p] && cdb_tag[p*4 +: 4] == tag) return {1'b1, cdb_value[p*64 +: 64]};
        return '0;
    endfunction

    function automatic logic [4:0] cdbFlags(input logic [3:0] tag);
        for (int p = 0; p < 2; p++)
            if (cdb_valid[p] && cdb_set_nzcv[p] && cdb_tag[p*4 +: 4] == tag) return {1'b1, cdb_nzcv[p*4 +: 4]};
        return '0;
    endfunction

    task automatic checkModel();
        int idx;
        idx = firstReady();
        checkOutput("count", count, q.size());
        checkOutput("disp_ready", disp_ready, (q.size() < 8) && !flush);
        checkOutput("issue_valid", issue_valid, idx >= 0);
        if (idx >= 0) begin
            checkOutput("issue_op", issue_op, q[idx].op);
            checkOutput("issue_dst", issue_dst, q[idx].dst);
            checkOutput("issue_src", issue_src, q[idx].val);
            checkOutput("issue_nzcv", issue_nzcv, q[idx].nz);
        end else begin
            checkOutput("idle_data", {issue_op, issue_dst, issue_nzcv, issue_src}, '0);
        end
    endtask

    task automatic modelStep();
        int   idx, n0;
        ent_t e;
        logic [64:0] hv;
        logic [4:0]  hf;
        n0  = q.size();
        idx = firstReady();
        if (rst || flush) begin
            q.delete();
            return;
        end
        for (int i = 0; i < q.size(); i++) begin
            e = q[i];
            for (int s = 0; s < 2; s++) begin
                hv = cdbValue(e.tag[s]);
                if (!e.sv[s] && hv[64]) begin
                    e.sv[s]  = 1'b1;
                    e.val[s] = hv[63:0];
                end
            end
            hf = cdbFlags(e.ntag);
            if (e.un && !e.nv && hf[4]) begin
                e.nv = 1'b1;
                e.nz = hf[3:0];
            end
            q[i] = e;
        end
        if (issue_ready && idx >= 0) q.delete(idx);
        if (disp_valid && n0 < 8) begin
            e.op = disp_op; e.dst = disp_dst; e.un = uses_nzcv; e.ntag = nzcv_tag;
            e.nv = nzcv_valid; e.nz = disp_nzcv;
            for (int s = 0; s < 2; s++) begin
                e.tag[s] = src_tag[s*4 +: 4];
                e.sv[s]  = src_valid[s];
                e.val[s] = src_value[s*64 +: 64];
                hv = cdbValue(e.tag[s]);
                if (!e.sv[s] && hv[64]) begin
                    e.sv[s]  = 1'b1;
                    e.val[s] = hv[63:0];
                end
            end
            hf = cdbFlags(e.ntag);
            if (e.un && !e.nv && hf[4]) begin
                e.nv = 1'b1;
                e.nz = hf[3:0];
            end
            q.push_back(e);
        end
    endtask

    task automatic stepCycle();
        #1;
        checkModel();
        modelStep();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; flush = 0; disp_valid = 0; disp_op = 0; disp_dst = 0;
        src_valid = 0; src_value = 0; src_tag = 0;
        uses_nzcv = 0; nzcv_valid = 0; disp_nzcv = 0; nzcv_tag = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_value = 0; cdb_set_nzcv = 0; cdb_nzcv = 0;
        issue_ready = 0;
    endtask

    task automatic dispatch(input logic [3:0] dst, input logic [1:0] sv, input logic [63:0] v0, input logic [63:0] v1,
                            input logic [3:0] t0, input logic [3:0] t1);
        disp_valid = 1; disp_dst = dst; disp_op = {2'b10, dst};
        src_valid = sv; src_value = {v1, v0}; src_tag = {t1, t0};
        uses_nzcv = 0; nzcv_valid = 1; disp_nzcv = dst; nzcv_tag = 0;
    endtask

    task automatic broadcast(input int p, input logic [3:0] tag, input logic [63:0] value,
                             input logic set, input logic [3:0] nz);
        cdb_valid[p] = 1'b1;
        cdb_tag[p*4 +: 4] = tag;
        cdb_value[p*64 +: 64] = value;
        cdb_set_nzcv[p] = set;
        cdb_nzcv[p*4 +: 4] = nz;
    endtask

    task automatic applyStimulus();
        idle();
        rst         = ($urandom_range(0, 199) == 0);
        flush       = ($urandom_range(0, 39) == 0);
        disp_valid  = ($urandom_range(0, 99) < 60);
        disp_op     = 6'($urandom());
        disp_dst    = 4'($urandom());
        src_valid   = 2'($urandom());
        src_value   = {$urandom(), $urandom(), $urandom(), $urandom()};
        src_tag     = {1'b0, 3'($urandom()), 1'b0, 3'($urandom())};
        uses_nzcv   = 1'($urandom());
        nzcv_valid  = uses_nzcv ? 1'($urandom()) : 1'b1;
        disp_nzcv   = 4'($urandom());
        nzcv_tag    = {1'b0, 3'($urandom())};
        cdb_valid   = 2'($urandom());
        cdb_tag     = {1'b0, 3'($urandom()), 1'b0, 3'($urandom())};
        cdb_value   = {$urandom(), $urandom(), $urandom(), $urandom()};
        cdb_set_nzcv = 2'($urandom());
        cdb_nzcv    = 8'($urandom());
        issue_ready = ($urandom_range(0, 99) < 50);
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        q.delete();
        rst = 1;
        stepCycle();

        // single fully-valid entry
        idle(); dispatch(3, 2'b11, 5, 7, 0, 0); stepCycle();
        checkOutput("t1_valid", issue_valid, 1);
        checkOutput("t1_dst", issue_dst, 3);
        checkOutput("t1_src", issue_src, {64'd7, 64'd5});
        idle(); issue_ready = 1; stepCycle();
        checkOutput("t1_count", count, 0);

        // older waiting entry issues before younger ready one
        idle(); dispatch(1, 2'b10, 0, 64'h22, 9, 0); stepCycle();
        idle(); dispatch(2, 2'b11, 3, 4, 0, 0); broadcast(0, 9, 64'h10, 0, 0); stepCycle();
        checkOutput("t2_first", issue_dst, 1);
        checkOutput("t2_wake", issue_src[63:0], 64'h10);
        idle(); issue_ready = 1; stepCycle();
        checkOutput("t2_second", issue_dst, 2);
        idle(); issue_ready = 1; stepCycle();

        // insert-cycle bypass from port 1
        idle(); dispatch(5, 2'b01, 64'h33, 0, 0, 4); broadcast(1, 4, 64'hAB, 0, 0); stepCycle();
        checkOutput("t3_valid", issue_valid, 1);
        checkOutput("t3_bypass", issue_src[127:64], 64'hAB);
        idle(); issue_ready = 1; stepCycle();

        // full station, freed slot not reusable the same cycle
        idle(); dispatch(0, 2'b00, 0, 0, 12, 12); stepCycle();
        for (int k = 1; k < 8; k++) begin
            idle(); dispatch(4'(k), 2'b00, 0, 0, 13, 13); stepCycle();
        end
        checkOutput("t4_count_full", count, 8);
        checkOutput("t4_ready_full", disp_ready, 0);
        idle(); broadcast(0, 12, 64'h55, 0, 0); stepCycle();
        idle(); issue_ready = 1; dispatch(9, 2'b11, 1, 2, 0, 0); stepCycle();
        checkOutput("t4_refused", count, 7);
        idle(); dispatch(9, 2'b11, 1, 2, 0, 0); stepCycle();
        checkOutput("t4_accepted", count, 8);
        idle(); flush = 1; dispatch(10, 2'b11, 1, 2, 0, 0); stepCycle();

        // flag operand needs set_nzcv on the broadcast
        idle(); dispatch(6, 2'b11, 1, 2, 0, 0); uses_nzcv = 1; nzcv_valid = 0; nzcv_tag = 6; stepCycle();
        idle(); broadcast(0, 6, 0, 0, 4'b1111); stepCycle();
        idle(); stepCycle();
        checkOutput("t5_wait", issue_valid, 0);
        idle(); broadcast(0, 6, 0, 1, 4'b0100); stepCycle();
        checkOutput("t5_valid", issue_valid, 1);
        checkOutput("t5_nzcv", issue_nzcv, 4'b0100);
        idle(); issue_ready = 1; stepCycle();

        // flush and reset with a dispatch pending
        for (int k = 0; k < 5; k++) begin
            idle(); dispatch(4'(k), 2'b00, 0, 0, 14, 14); stepCycle();
        end
        idle(); flush = 1; dispatch(11, 2'b11, 1, 2, 0, 0); stepCycle();
        checkOutput("t6_flush_count", count, 0);
        checkOutput("t6_flush_valid", issue_valid, 0);
        for (int k = 0; k < 3; k++) begin
            idle(); dispatch(4'(k), 2'b00, 0, 0, 14, 14); stepCycle();
        end
        idle(); rst = 1; dispatch(12, 2'b11, 1, 2, 0, 0); stepCycle();
        checkOutput("t6_rst_count", count, 0);
        checkOutput("t6_rst_valid", issue_valid, 0);

        for (int c = 0; c < 800; c++) begin
            applyStimulus();
            stepCycle();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
